// File: rtl/evm_pkg.sv
// ----------------------------------------------------------------------------
// evm_pkg
// Shared types and constants for the EVM ballot controller slice.
//   - ballot_state_t : station sequencing states
//   - NUM_CAND       : number of candidate buttons / vote lines
//   - CAND_1..CAND_4 : candidate one-hot codes as seen on vote_pulse
//   - cand_count     : number of set bits in a candidate vector
//   - is_onehot      : exactly one candidate bit set
// ----------------------------------------------------------------------------
package evm_pkg;

    localparam int NUM_CAND = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAST    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } ballot_state_t;

    localparam logic [NUM_CAND-1:0] CAND_1 = 4'b0001;
    localparam logic [NUM_CAND-1:0] CAND_2 = 4'b0010;
    localparam logic [NUM_CAND-1:0] CAND_3 = 4'b0100;
    localparam logic [NUM_CAND-1:0] CAND_4 = 4'b1000;

    // Population count of a candidate vector (0..NUM_CAND fits in 3 bits).
    function automatic logic [2:0] cand_count(input logic [NUM_CAND-1:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_CAND; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

    function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
        return (cand_count(v) == 3'd1);
    endfunction

endpackage

// File: rtl/evm_btn_sampler.sv
// ----------------------------------------------------------------------------
// evm_btn_sampler
// Registers the candidate button levels and derives the press qualifiers the
// ballot FSM needs.
//   clk, reset : clock, asynchronous active-low reset
//   btn        : raw candidate button levels (synchronous to clk)
//   btn_q      : btn delayed by one cycle
//   press      : rising edges, btn & ~btn_q
//   multi      : two or more buttons currently held
//   any        : at least one button currently held
// ----------------------------------------------------------------------------
module evm_btn_sampler
    import evm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CAND-1:0] btn,
    output logic [NUM_CAND-1:0] btn_q,
    output logic [NUM_CAND-1:0] press,
    output logic                multi,
    output logic                any
);

    // Previous-cycle button snapshot for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q <= {NUM_CAND{1'b0}};
        end else begin
            btn_q <= btn;
        end
    end

    assign press = btn & ~btn_q;
    assign multi = (cand_count(btn) >= 3'd2);
    assign any   = (btn != {NUM_CAND{1'b0}});

endmodule

// File: rtl/evm_ballot_controller.sv
// ----------------------------------------------------------------------------
// evm_ballot_controller
// Single voting station sequencer in front of the EVM vote counter. Gates the
// candidate buttons behind an officer-issued ballot, allows one vote per
// ballot, rejects multi-button and unsolicited presses, voids idle ballots
// after TIMEOUT_CYCLES and handles poll open/close.
//   clk, reset    : clock, asynchronous active-low reset
//   poll_open     : pulse, opens the poll from IDLE
//   poll_close    : pulse, requests close (takes effect at a safe point)
//   ballot_req    : pulse, officer issues one ballot (WAIT only)
//   btn           : candidate button levels
//   vote_pulse    : one-cycle one-hot accepted vote
//   ballot_ready  : voter lamp, ballot armed
//   station_free  : officer lamp, ballot may be issued
//   reject        : one-cycle illegal-press pulse
//   timeout       : one-cycle armed-ballot expiry pulse
//   total_votes   : saturating count of accepted votes since poll open
//   results_valid : poll closed
// ----------------------------------------------------------------------------
module evm_ballot_controller
    import evm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TOTAL_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                poll_open,
    input  logic                poll_close,
    input  logic                ballot_req,
    input  logic [NUM_CAND-1:0] btn,
    output logic [NUM_CAND-1:0] vote_pulse,
    output logic                ballot_ready,
    output logic                station_free,
    output logic                reject,
    output logic                timeout,
    output logic [TOTAL_W-1:0]  total_votes,
    output logic                results_valid
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [TOTAL_W-1:0] TOTAL_ZERO = {TOTAL_W{1'b0}};
    localparam logic [TOTAL_W-1:0] TOTAL_ONE  = {{(TOTAL_W-1){1'b0}}, 1'b1};
    localparam logic [TOTAL_W-1:0] TOTAL_MAX  = {TOTAL_W{1'b1}};

    ballot_state_t       state_r;
    logic [TIMER_W-1:0]  timer_r;
    logic                close_pending_r;

    ballot_state_t       state_nxt_s;
    logic [TIMER_W-1:0]  timer_nxt_s;
    logic                close_pending_nxt_s;
    logic [TOTAL_W-1:0]  total_nxt_s;
    logic [NUM_CAND-1:0] vote_nxt_s;
    logic                reject_nxt_s;
    logic                timeout_nxt_s;

    // The delayed button vector is only needed inside the sampler; kept as a
    // named net so it stays visible for debug.
    logic [NUM_CAND-1:0] btn_q_unused_s;
    logic [NUM_CAND-1:0] press_s;
    logic                multi_s;
    logic                any_s;

    evm_btn_sampler u_btn_sampler (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .btn_q (btn_q_unused_s),
        .press (press_s),
        .multi (multi_s),
        .any   (any_s)
    );

    // Next-state, timer, counter and output-pulse decode.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        total_nxt_s   = total_votes;
        vote_nxt_s    = {NUM_CAND{1'b0}};
        reject_nxt_s  = 1'b0;
        timeout_nxt_s = 1'b0;

        // A close request is remembered until the station reaches a point
        // where it can stop without losing a vote in flight.
        if (poll_close && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
            close_pending_nxt_s = 1'b1;
        end else begin
            close_pending_nxt_s = close_pending_r;
        end

        case (state_r)
            ST_IDLE: begin
                reject_nxt_s = |press_s;
                if (poll_open) begin
                    state_nxt_s         = ST_WAIT;
                    total_nxt_s         = TOTAL_ZERO;
                    close_pending_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_WAIT: begin
                if (close_pending_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    reject_nxt_s = |press_s;
                    if (ballot_req) begin
                        state_nxt_s = ST_ARMED;
                        timer_nxt_s = TIMER_LOAD;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
            end

            ST_ARMED: begin
                if (timer_r != TIMER_ZERO) begin
                    timer_nxt_s = timer_r - TIMER_ONE;
                end else begin
                    timer_nxt_s = timer_r;
                end
                // Priority: close, multi-press, valid press, expiry.
                if (close_pending_r) begin
                    state_nxt_s = ST_DONE;
                end else if (multi_s) begin
                    reject_nxt_s = 1'b1;
                end else if (is_onehot(press_s)) begin
                    state_nxt_s = ST_CAST;
                    vote_nxt_s  = press_s;
                end else if (timer_r == TIMER_ZERO) begin
                    state_nxt_s   = ST_WAIT;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end

            ST_CAST: begin
                // vote_pulse is already high this cycle; count it and move on.
                if (total_votes != TOTAL_MAX) begin
                    total_nxt_s = total_votes + TOTAL_ONE;
                end else begin
                    total_nxt_s = total_votes;
                end
                state_nxt_s = ST_RELEASE;
            end

            ST_RELEASE: begin
                if (close_pending_r) begin
                    state_nxt_s = ST_DONE;
                end else if (!any_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end

            ST_DONE: begin
                reject_nxt_s = |press_s;
                state_nxt_s  = ST_DONE;
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs; lamps follow the next state
    // so they are valid in the same cycle the state is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            timer_r         <= TIMER_ZERO;
            close_pending_r <= 1'b0;
            vote_pulse      <= {NUM_CAND{1'b0}};
            ballot_ready    <= 1'b0;
            station_free    <= 1'b0;
            reject          <= 1'b0;
            timeout         <= 1'b0;
            total_votes     <= TOTAL_ZERO;
            results_valid   <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            timer_r         <= timer_nxt_s;
            close_pending_r <= close_pending_nxt_s;
            vote_pulse      <= vote_nxt_s;
            ballot_ready    <= (state_nxt_s == ST_ARMED);
            station_free    <= (state_nxt_s == ST_WAIT);
            reject          <= reject_nxt_s;
            timeout         <= timeout_nxt_s;
            total_votes     <= total_nxt_s;
            results_valid   <= (state_nxt_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_evm_ballot_controller.sv
// ----------------------------------------------------------------------------
// tb_evm_ballot_controller
// Directed self-checking bench for evm_ballot_controller (TIMEOUT_CYCLES=20).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_evm_ballot_controller;

    localparam int TO = 20;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          poll_open = 1'b0;
    logic          poll_close = 1'b0;
    logic          ballot_req = 1'b0;
    logic [3:0]    btn = 4'b0000;
    logic [3:0]    vote_pulse;
    logic          ballot_ready;
    logic          station_free;
    logic          reject;
    logic          timeout;
    logic [TW-1:0] total_votes;
    logic          results_valid;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    evm_ballot_controller #(
        .TIMEOUT_CYCLES (TO),
        .TOTAL_W        (TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .poll_open     (poll_open),
        .poll_close    (poll_close),
        .ballot_req    (ballot_req),
        .btn           (btn),
        .vote_pulse    (vote_pulse),
        .ballot_ready  (ballot_ready),
        .station_free  (station_free),
        .reject        (reject),
        .timeout       (timeout),
        .total_votes   (total_votes),
        .results_valid (results_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        tests_run++;
        if ({vote_pulse, ballot_ready, station_free, reject, timeout, results_valid} !== 9'd0 || total_votes !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got vote=%b rdy=%b free=%b rej=%b to=%b rv=%b tot=%0d want all 0",
                     vote_pulse, ballot_ready, station_free, reject, timeout, results_valid, total_votes);
        end
        reset = 1'b1;
        tick();
        poll_close = 1'b1;           // ignored in IDLE
        tick();
        poll_close = 1'b0;
        tick();
        tests_run++;
        if (station_free !== 1'b0 || results_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_close_ignored got free=%b rv=%b want 0 0", station_free, results_valid);
        end
    endtask

    task automatic test_single_vote();
        poll_open = 1'b1; tick(); poll_open = 1'b0;
        tests_run++;
        if (station_free !== 1'b1 || total_votes !== 16'd0) begin
            tests_failed++;
            $display("FAIL open_wait got free=%b tot=%0d want 1 0", station_free, total_votes);
        end
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        tests_run++;
        if (ballot_ready !== 1'b1 || station_free !== 1'b0) begin
            tests_failed++;
            $display("FAIL armed_lamps got rdy=%b free=%b want 1 0", ballot_ready, station_free);
        end
        btn = 4'b0001; tick();
        tests_run++;
        if (vote_pulse !== 4'b0001 || total_votes !== 16'd0 || ballot_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL vote1_pulse got vote=%b tot=%0d rdy=%b want 0001 0 0", vote_pulse, total_votes, ballot_ready);
        end
        tick();
        tests_run++;
        if (vote_pulse !== 4'b0000 || total_votes !== 16'd1) begin
            tests_failed++;
            $display("FAIL vote1_count got vote=%b tot=%0d want 0000 1", vote_pulse, total_votes);
        end
        tick();
        tests_run++;
        if (station_free !== 1'b0 || vote_pulse !== 4'b0000) begin
            tests_failed++;
            $display("FAIL vote1_held got free=%b vote=%b want 0 0000", station_free, vote_pulse);
        end
        btn = 4'b0000; tick();
        tests_run++;
        if (station_free !== 1'b1 || total_votes !== 16'd1) begin
            tests_failed++;
            $display("FAIL vote1_release got free=%b tot=%0d want 1 1", station_free, total_votes);
        end
    endtask

    task automatic test_multi_reject();
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        btn = 4'b0101; tick();
        tests_run++;
        if (reject !== 1'b1 || vote_pulse !== 4'b0000 || ballot_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL multi_reject got rej=%b vote=%b rdy=%b want 1 0000 1", reject, vote_pulse, ballot_ready);
        end
        btn = 4'b0000; tick();
        tests_run++;
        if (reject !== 1'b0 || ballot_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL multi_after got rej=%b rdy=%b want 0 1", reject, ballot_ready);
        end
        btn = 4'b0100; tick();
        tests_run++;
        if (vote_pulse !== 4'b0100 || reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL vote3_pulse got vote=%b rej=%b want 0100 0", vote_pulse, reject);
        end
        btn = 4'b0000; tick();
        tick();
        tests_run++;
        if (total_votes !== 16'd2 || station_free !== 1'b1) begin
            tests_failed++;
            $display("FAIL vote3_count got tot=%0d free=%b want 2 1", total_votes, station_free);
        end
    endtask

    task automatic test_timeout();
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        for (int k = 1; k < TO; k++) begin
            tick();
            tests_run++;
            if (timeout !== 1'b0 || ballot_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL timeout_early cyc=%0d got to=%b rdy=%b want 0 1", k, timeout, ballot_ready);
            end
        end
        tick();
        tests_run++;
        if (timeout !== 1'b1 || station_free !== 1'b1 || ballot_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_fire got to=%b free=%b rdy=%b want 1 1 0", timeout, station_free, ballot_ready);
        end
        tick();
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_oneshot got to=%b want 0", timeout);
        end
        btn = 4'b0010; tick();
        tests_run++;
        if (reject !== 1'b1 || vote_pulse !== 4'b0000) begin
            tests_failed++;
            $display("FAIL post_timeout_press got rej=%b vote=%b want 1 0000", reject, vote_pulse);
        end
        btn = 4'b0000; tick(); tick();
        tests_run++;
        if (total_votes !== 16'd2 || reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_timeout_total got tot=%0d rej=%b want 2 0", total_votes, reject);
        end
    endtask

    task automatic test_wait_press_hold();
        btn = 4'b1000; tick();
        tests_run++;
        if (reject !== 1'b1 || vote_pulse !== 4'b0000 || station_free !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_press got rej=%b vote=%b free=%b want 1 0000 1", reject, vote_pulse, station_free);
        end
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        tests_run++;
        if (ballot_ready !== 1'b1 || reject !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_arm got rdy=%b rej=%b want 1 0", ballot_ready, reject);
        end
        tick(); tick();
        tests_run++;
        if (vote_pulse !== 4'b0000 || ballot_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_no_vote got vote=%b rdy=%b want 0000 1", vote_pulse, ballot_ready);
        end
        btn = 4'b0000; tick();
        btn = 4'b1000; tick();
        tests_run++;
        if (vote_pulse !== 4'b1000) begin
            tests_failed++;
            $display("FAIL repress_vote got vote=%b want 1000", vote_pulse);
        end
        btn = 4'b0000; tick(); tick();
        tests_run++;
        if (total_votes !== 16'd3 || station_free !== 1'b1) begin
            tests_failed++;
            $display("FAIL repress_count got tot=%0d free=%b want 3 1", total_votes, station_free);
        end
    endtask

    task automatic test_close_in_cast();
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        btn = 4'b0001; tick();
        poll_close = 1'b1; btn = 4'b0000;
        tests_run++;
        if (vote_pulse !== 4'b0001) begin
            tests_failed++;
            $display("FAIL cast_close_vote got vote=%b want 0001", vote_pulse);
        end
        tick(); poll_close = 1'b0;
        tests_run++;
        if (total_votes !== 16'd4 || results_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL cast_close_count got tot=%0d rv=%b want 4 0", total_votes, results_valid);
        end
        tick();
        tests_run++;
        if (results_valid !== 1'b1 || station_free !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_enter got rv=%b free=%b want 1 0", results_valid, station_free);
        end
        poll_open = 1'b1; tick(); poll_open = 1'b0;
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        tick();
        tests_run++;
        if (results_valid !== 1'b1 || station_free !== 1'b0 || ballot_ready !== 1'b0 || total_votes !== 16'd4) begin
            tests_failed++;
            $display("FAIL done_terminal got rv=%b free=%b rdy=%b tot=%0d want 1 0 0 4",
                     results_valid, station_free, ballot_ready, total_votes);
        end
        btn = 4'b0010; tick();
        tests_run++;
        if (reject !== 1'b1 || vote_pulse !== 4'b0000 || total_votes !== 16'd4) begin
            tests_failed++;
            $display("FAIL done_press got rej=%b vote=%b tot=%0d want 1 0000 4", reject, vote_pulse, total_votes);
        end
        btn = 4'b0000; tick();
    endtask

    task automatic test_reset_mid_armed();
        reset = 1'b0; #4; reset = 1'b1;
        tick();
        poll_open = 1'b1; tick(); poll_open = 1'b0;
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        tests_run++;
        if (ballot_ready !== 1'b1 || total_votes !== 16'd0 || results_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rearm got rdy=%b tot=%0d rv=%b want 1 0 0", ballot_ready, total_votes, results_valid);
        end
        #3; reset = 1'b0; #1;
        tests_run++;
        if ({vote_pulse, ballot_ready, station_free, reject, timeout, results_valid} !== 9'd0 || total_votes !== 16'd0) begin
            tests_failed++;
            $display("FAIL async_reset_armed got rdy=%b free=%b rv=%b tot=%0d want all 0",
                     ballot_ready, station_free, results_valid, total_votes);
        end
        #1; reset = 1'b1;
        tick();
        tests_run++;
        if (station_free !== 1'b0 || ballot_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle got free=%b rdy=%b want 0 0", station_free, ballot_ready);
        end
        poll_open = 1'b1; tick(); poll_open = 1'b0;
        tests_run++;
        if (station_free !== 1'b1 || total_votes !== 16'd0) begin
            tests_failed++;
            $display("FAIL reopen got free=%b tot=%0d want 1 0", station_free, total_votes);
        end
        // Reset while CAST is active: the vote must not come out afterwards.
        ballot_req = 1'b1; tick(); ballot_req = 1'b0;
        btn = 4'b0010; tick();
        #2; reset = 1'b0; #2; reset = 1'b1;
        btn = 4'b0000; tick();
        tests_run++;
        if (vote_pulse !== 4'b0000 || total_votes !== 16'd0 || station_free !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_cast got vote=%b tot=%0d free=%b want 0000 0 0", vote_pulse, total_votes, station_free);
        end
    endtask

    initial begin
        test_reset();
        test_single_vote();
        test_multi_reject();
        test_timeout();
        test_wait_press_hold();
        test_close_in_cast();
        test_reset_mid_armed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/evm_ballot_controller.md
# evm_ballot_controller

Sequences a single voting station in front of the EVM vote counter. It gates the four raw candidate buttons behind a presiding-officer ballot issue and enforces one vote per ballot. Multi-button presses are rejected and unused ballots time out. The output is clean one-cycle one-hot vote pulses that drive the counter's candidate inputs, plus poll open/close sequencing and a station-level total.

## Interface
- `TIMEOUT_CYCLES`, 1000: cycles an armed ballot waits for a press before it is voided (≥1).
- `TOTAL_W`, 16: width of the station vote total.
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `poll_open`  in  1: one-cycle pulse; opens the poll from IDLE.
- `poll_close`  in  1: one-cycle pulse; requests poll close.
- `ballot_req`  in  1: one-cycle pulse from officer; issues one ballot.
- `btn`  in  4: candidate buttons, synchronous levels, bit i = candidate i+1.
- `vote_pulse`  out  4: one-hot, one cycle per accepted vote; connects to the counter's `v1..v4`.
- `ballot_ready`  out  1: voter lamp; high while a ballot is armed.
- `station_free`  out  1: officer lamp; high when a ballot may be issued.
- `reject`  out  1: one-cycle pulse on an illegal press.
- `timeout`  out  1: one-cycle pulse when an armed ballot expires.
- `total_votes`  out  TOTAL_W: votes accepted since poll open.
- `results_valid`  out  1: high once the poll is closed.

## Operation
- States are IDLE, WAIT, ARMED, CAST, RELEASE and DONE.
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - The `btn` sample register, the timer and the close-pending flag are all 0.
- IDLE:
  - `poll_open` moves to WAIT and clears `total_votes`.
  - `poll_close` is ignored.
- WAIT:
  - `station_free`=1.
  - `ballot_req` moves to ARMED and loads the timer with TIMEOUT_CYCLES-1.
- ARMED:
  - `ballot_ready`=1 and the timer decrements each cycle.
  - Define press = `btn & ~btn_q` (rising edges).
  - If popcount(`btn`) ≥ 2 in any cycle: pulse `reject` and stay ARMED. The timer is not reloaded.
  - Else if press is one-hot: latch the candidate and go to CAST.
  - Else if the timer = 0: pulse `timeout` and return to WAIT. The ballot is voided.
  - A valid press in the expiry cycle wins over the timeout.
- CAST:
  - `vote_pulse` = latched one-hot for exactly one cycle.
  - `total_votes` increments, saturating at all-ones.
  - Go to RELEASE.
- RELEASE: stay until `btn`==0, then go to WAIT. Presses in RELEASE are ignored and do not reject.
- A rising edge on any `btn` in IDLE, WAIT or DONE pulses `reject`; no vote is counted.
- `ballot_req` outside WAIT is ignored.
- Close handling:
  - `poll_close` in any state other than IDLE/DONE sets close-pending.
  - From WAIT, ARMED or RELEASE with close-pending set, go to DONE. Any armed ballot is voided with no `timeout` pulse.
  - CAST always completes first, so a vote in flight is counted.
  - Close-pending wins over a same-cycle `ballot_req` or press.
- DONE:
  - `results_valid`=1 and `total_votes` is frozen.
  - Terminal until `reset`; `poll_open` is ignored.

## Timing
- Sample `btn` high at edge N with `btn_q` low: state is CAST after N, `vote_pulse` is high for cycle N→N+1, and `total_votes` updates at N+1.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- `ballot_ready` rises one cycle after `ballot_req` is sampled.
- `timeout` fires exactly TIMEOUT_CYCLES cycles after ARMED is entered.
- Async reset mid-CAST: no `vote_pulse` is emitted after reset deasserts.
- `vote_pulse` can never be multi-hot.
- Consecutive votes are at least 3 cycles apart: CAST, RELEASE, WAIT.

## Structure
- `evm_pkg`:
  - `ballot_state_t` enum.
  - `NUM_CAND`=4.
  - Candidate one-hot constants.
- Sub-module `evm_btn_sampler`: registers `btn` and outputs `btn_q`, `press`, `multi` (popcount ≥ 2) and `any` (`btn` ≠ 0).
- The FSM, timer, close-pending flag and total counter live in the top.

## Test plan
- Open the poll, issue a ballot, press `btn`=0001 for 3 cycles → one `vote_pulse`=0001, `total_votes`=1, then WAIT after release.
- ARMED with `btn`=0101 → `reject` pulse, no vote, still ARMED. Then `btn`=0100 alone → `vote_pulse`=0100.
- TIMEOUT_CYCLES=20, issue a ballot with no press → `timeout` on cycle 20, `station_free`=1. A press afterwards → `reject`, `total_votes` unchanged.
- Press in WAIT with no ballot → `reject`, no `vote_pulse`. Hold the button through a new `ballot_req` → no vote until release and re-press.
- `poll_close` during CAST → `vote_pulse` still emitted, then DONE with `results_valid`=1. A later `poll_open` or `ballot_req` is ignored.
- Assert `reset` low mid-ARMED → all outputs 0 and state IDLE. `poll_open` then restarts with `total_votes`=0.
